// File: rtl/pe_array_pkg.sv
// Shared types and instruction field layout for the PE array sequencer.
// Optional feature macro PE_ALU_MUL_EN (read by pe_alu) turns alu_op 11 into multiply.
package pe_array_pkg;

    typedef enum logic [1:0] {
        ADD     = 2'b00,
        SUB     = 2'b01,
        AND     = 2'b10,
        XOR_MUL = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } seq_state_t;

    // Instruction word, MSB to LSB: op0, op1, use_imm0, use_imm1, alu_op[1:0]
    localparam int unsigned ALU_OP_LSB = 0;
    localparam int unsigned ALU_OP_W   = 2;
    localparam int unsigned IMM1_BIT   = 2;
    localparam int unsigned IMM0_BIT   = 3;
    localparam int unsigned OP1_LSB    = 4;

    function automatic int unsigned op0_lsb(input int unsigned data_w);
        return OP1_LSB + data_w;
    endfunction

    function automatic int unsigned instr_w(input int unsigned data_w);
        return 2 * data_w + 4;
    endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Instruction-in / result-out handshake bundle of the PE array sequencer.
interface pe_array_sequencer_if #(
    parameter int unsigned NUM_PE = 8,
    parameter int unsigned DATA_W = 4
);
    localparam int unsigned PE_IDX_W = $clog2(NUM_PE);
    localparam int unsigned INSTR_W  = pe_array_pkg::instr_w(DATA_W);

    logic [INSTR_W-1:0]  instr;
    logic                instr_valid;
    logic                instr_last;
    logic                instr_ready;
    logic [DATA_W-1:0]   result;
    logic                result_valid;
    logic                result_ready;
    logic [PE_IDX_W-1:0] result_pe;

    modport master (
        output instr, instr_valid, instr_last, result_ready,
        input  instr_ready, result, result_valid, result_pe
    );

    modport slave (
        input  instr, instr_valid, instr_last, result_ready,
        output instr_ready, result, result_valid, result_pe
    );
endinterface

// File: rtl/pe_array_sequencer_alu.sv
// Combinational PE ALU, results modulo 2^DATA_W.
// With PE_ALU_MUL_EN defined, XOR_MUL multiplies (low DATA_W bits); otherwise it is xor.
module pe_alu
    import pe_array_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = '0;
        unique case (op)
            ADD:     y = DATA_W'(a + b);
            SUB:     y = DATA_W'(a - b);
            AND:     y = a & b;
`ifdef PE_ALU_MUL_EN
            XOR_MUL: y = DATA_W'(a * b);
`else
            XOR_MUL: y = a ^ b;
`endif
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/pe_array_sequencer.sv
// Loads a program into NUM_PE slots with feed-forward operand checking, runs it one PE per cycle
// and returns the last slot's result. Optional macro PE_ALU_MUL_EN is honoured inside pe_alu.
module pe_array_sequencer
    import pe_array_pkg::*;
#(
    parameter  int unsigned NUM_PE   = 8,
    parameter  int unsigned DATA_W   = 4,
    localparam int unsigned PE_IDX_W = $clog2(NUM_PE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    pe_array_sequencer_if.slave bus,
    output logic                busy,
    output logic                fault,
    output logic [PE_IDX_W-1:0] fault_pe
);
    localparam int unsigned INSTR_W = instr_w(DATA_W);
    localparam int unsigned OP0_LSB = op0_lsb(DATA_W);
    localparam int unsigned LAST_PE = NUM_PE - 1;

    if (DATA_W < PE_IDX_W) begin : g_bad_data_w
        $error("pe_array_sequencer: DATA_W must be >= $clog2(NUM_PE)");
    end
    if (NUM_PE < 2 || NUM_PE > 16 || (NUM_PE & (NUM_PE - 1)) != 0) begin : g_bad_num_pe
        $error("pe_array_sequencer: NUM_PE must be a power of two in 2..16");
    end

    seq_state_t          r_state;
    logic [INSTR_W-1:0]  r_slot [NUM_PE];
    logic [DATA_W-1:0]   r_res  [NUM_PE];
    logic [PE_IDX_W-1:0] r_load_cnt;
    logic [PE_IDX_W-1:0] r_exec_cnt;
    logic [PE_IDX_W-1:0] r_last_idx;
    logic [DATA_W-1:0]   r_result;
    logic [PE_IDX_W-1:0] r_result_pe;
    logic                r_result_valid;
    logic                r_instr_ready;
    logic                r_busy;
    logic                r_fault;
    logic [PE_IDX_W-1:0] r_fault_pe;

    logic                w_xfer;
    logic                w_legal;
    logic [PE_IDX_W-1:0] w_in_idx0;
    logic [PE_IDX_W-1:0] w_in_idx1;
    logic [INSTR_W-1:0]  w_exec;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    alu_op_t             w_op;
    logic [DATA_W-1:0]   w_alu_y;

    // An operand may only read a slot strictly before the one being loaded.
    assign w_xfer    = bus.instr_valid && r_instr_ready;
    assign w_in_idx0 = bus.instr[OP0_LSB +: PE_IDX_W];
    assign w_in_idx1 = bus.instr[OP1_LSB +: PE_IDX_W];
    assign w_legal   = (bus.instr[IMM0_BIT] || (w_in_idx0 < r_load_cnt)) &&
                       (bus.instr[IMM1_BIT] || (w_in_idx1 < r_load_cnt));

    assign w_exec = r_slot[r_exec_cnt];
    assign w_a    = w_exec[IMM0_BIT] ? w_exec[OP0_LSB +: DATA_W]
                                     : r_res[w_exec[OP0_LSB +: PE_IDX_W]];
    assign w_b    = w_exec[IMM1_BIT] ? w_exec[OP1_LSB +: DATA_W]
                                     : r_res[w_exec[OP1_LSB +: PE_IDX_W]];
    assign w_op   = alu_op_t'(w_exec[ALU_OP_LSB +: ALU_OP_W]);

    pe_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (w_a),
        .b  (w_b),
        .op (w_op),
        .y  (w_alu_y)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_load_cnt     <= '0;
            r_exec_cnt     <= '0;
            r_last_idx     <= '0;
            r_result       <= '0;
            r_result_pe    <= '0;
            r_result_valid <= 1'b0;
            r_instr_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_pe     <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                r_slot[i] <= '0;
                r_res[i]  <= '0;
            end
        end else if (clear) begin
            r_state        <= ST_IDLE;
            r_load_cnt     <= '0;
            r_exec_cnt     <= '0;
            r_result_valid <= 1'b0;
            r_instr_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_pe     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_xfer) begin
                        r_busy <= 1'b1;
                        if (!w_legal) begin
                            r_state       <= ST_FAULT;
                            r_fault       <= 1'b1;
                            r_fault_pe    <= r_load_cnt;
                            r_instr_ready <= 1'b0;
                        end else begin
                            r_slot[r_load_cnt] <= bus.instr;
                            if (bus.instr_last || r_load_cnt == PE_IDX_W'(LAST_PE)) begin
                                r_state       <= ST_RUN;
                                r_last_idx    <= r_load_cnt;
                                r_exec_cnt    <= '0;
                                r_instr_ready <= 1'b0;
                            end else begin
                                r_state    <= ST_LOAD;
                                r_load_cnt <= r_load_cnt + PE_IDX_W'(1);
                            end
                        end
                    end
                end
                ST_RUN: begin
                    r_res[r_exec_cnt] <= w_alu_y;
                    if (r_exec_cnt == r_last_idx) begin
                        r_state        <= ST_DONE;
                        r_result       <= w_alu_y;
                        r_result_pe    <= r_exec_cnt;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_exec_cnt <= r_exec_cnt + PE_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        r_state        <= ST_IDLE;
                        r_load_cnt     <= '0;
                        r_result_valid <= 1'b0;
                        r_instr_ready  <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                default: begin
                    // ST_FAULT holds until clear
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign bus.instr_ready  = r_instr_ready;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.result_pe    = r_result_pe;
    assign busy             = r_busy;
    assign fault            = r_fault;
    assign fault_pe         = r_fault_pe;
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer (NUM_PE=4, DATA_W=4): vector table, corner sequences, random programs.
module tb_pe_array_sequencer;
    localparam int unsigned NUM_PE = 4;
    localparam int unsigned DATA_W = 4;

`ifdef PE_ALU_MUL_EN
    localparam logic [3:0] OP3_3_6   = 4'h2;
    localparam logic [3:0] CHAIN_RES = 4'h7;
`else
    localparam logic [3:0] OP3_3_6   = 4'h5;
    localparam logic [3:0] CHAIN_RES = 4'h6;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       busy;
    logic       fault;
    logic [1:0] fault_pe;

    pe_array_sequencer_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) bus ();

    pe_array_sequencer #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus),
        .busy     (busy),
        .fault    (fault),
        .fault_pe (fault_pe)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ia;
        logic       ib;
        logic [1:0] op;
    } pe_instr_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] exp;
    } vec_t;

    vec_t      vecs [6];
    pe_instr_t prog [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] mk(input pe_instr_t p);
        return {p.a, p.b, p.ia, p.ib, p.op};
    endfunction

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int unsigned r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = 16 + int'(a) - int'(b);
            2'd2:    r = int'(a & b);
`ifdef PE_ALU_MUL_EN
            default: r = int'(a) * int'(b);
`else
            default: r = int'(a ^ b);
`endif
        endcase
        return 4'(r % 16);
    endfunction

    task automatic send(input pe_instr_t p, input logic last);
        int n = 0;
        bus.instr       = mk(p);
        bus.instr_valid = 1'b1;
        bus.instr_last  = last;
        while (!bus.instr_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input int lat, input logic [3:0] res, input int pe);
        int n = 0;
        while (!bus.result_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(lat));
        check({name, "_result"}, 32'(bus.result), 32'(res));
        check({name, "_result_pe"}, 32'(bus.result_pe), 32'(pe));
    endtask

    task automatic take_result(input string name);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(bus.result_valid), 32'd0);
        check({name, "_ready_back"}, 32'(bus.instr_ready), 32'd1);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic pe_instr_t pi(input logic [3:0] a, input logic [3:0] b,
                                     input logic ia, input logic ib, input logic [1:0] op);
        pe_instr_t p;
        p.a = a; p.b = b; p.ia = ia; p.ib = ib; p.op = op;
        return p;
    endfunction

    task automatic send_chain();
        send(pi(4'h7, 4'h6, 1'b1, 1'b1, 2'd0), 1'b0);
        send(pi(4'h0, 4'h4, 1'b0, 1'b1, 2'd1), 1'b0);
        send(pi(4'h1, 4'h0, 1'b0, 1'b0, 2'd2), 1'b0);
        send(pi(4'h2, 4'hF, 1'b0, 1'b1, 2'd3), 1'b0);
    endtask

    // Reference: walk the program slot by slot using plain values
    task automatic run_random(input int n, input bit use_last);
        logic [3:0] v [4];
        bit         flt = 1'b0;
        int         fpe = 0;
        int         stop;
        for (int k = 0; k < n && !flt; k++) begin
            if ((!prog[k].ia && int'(prog[k].a % 4) >= k) ||
                (!prog[k].ib && int'(prog[k].b % 4) >= k)) begin
                flt = 1'b1;
                fpe = k;
            end else begin
                v[k] = ref_alu(prog[k].ia ? prog[k].a : v[prog[k].a % 4],
                               prog[k].ib ? prog[k].b : v[prog[k].b % 4], prog[k].op);
            end
        end
        stop = flt ? fpe : n - 1;
        for (int k = 0; k <= stop; k++) send(prog[k], use_last && k == n - 1);
        if (flt) begin
            check("rnd_fault", 32'(fault), 32'd1);
            check("rnd_fault_pe", 32'(fault_pe), 32'(fpe));
            check("rnd_fault_ready", 32'(bus.instr_ready), 32'd0);
            pulse_clear();
            check("rnd_fault_cleared", 32'(fault), 32'd0);
        end else begin
            wait_result("rnd", n, v[n - 1], n - 1);
            take_result("rnd");
        end
    endtask

    function automatic logic [3:0] rnd_operand(input int k, output logic imm);
        if (k == 0) imm = ($urandom % 10) != 0;
        else        imm = ($urandom % 2) != 0;
        if (!imm && k > 0 && ($urandom % 8) != 0)
            return 4'(($urandom % 4) * 4 + $urandom_range(0, k - 1));
        return 4'($urandom % 16);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{a: 4'h3, b: 4'h5, op: 2'd0, exp: 4'h8};
        vecs[1] = '{a: 4'hF, b: 4'h2, op: 2'd0, exp: 4'h1};
        vecs[2] = '{a: 4'h0, b: 4'h1, op: 2'd1, exp: 4'hF};
        vecs[3] = '{a: 4'h3, b: 4'h6, op: 2'd3, exp: OP3_3_6};
        vecs[4] = '{a: 4'hC, b: 4'hA, op: 2'd2, exp: 4'h8};
        vecs[5] = '{a: 4'h9, b: 4'h5, op: 2'd1, exp: 4'h4};

        bus.instr        = '0;
        bus.instr_valid  = 1'b0;
        bus.instr_last   = 1'b0;
        bus.result_ready = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            send(pi(vecs[i].a, vecs[i].b, 1'b1, 1'b1, vecs[i].op), 1'b1);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            wait_result($sformatf("vec%0d", i), 1, vecs[i].exp, 0);
            take_result($sformatf("vec%0d", i));
        end

        send_chain();
        check("chain_ready_low", 32'(bus.instr_ready), 32'd0);
        wait_result("chain", 4, CHAIN_RES, 3);
        take_result("chain");

        send(pi(4'h1, 4'h2, 1'b1, 1'b1, 2'd0), 1'b0);
        send(pi(4'h1, 4'h0, 1'b0, 1'b1, 2'd0), 1'b0);
        check("self_fault", 32'(fault), 32'd1);
        check("self_fault_pe", 32'(fault_pe), 32'd1);
        check("self_fault_ready", 32'(bus.instr_ready), 32'd0);
        check("self_fault_busy", 32'(busy), 32'd1);
        tick();
        check("self_fault_sticky", 32'(fault), 32'd1);
        pulse_clear();
        check("clear_fault", 32'(fault), 32'd0);
        check("clear_fault_pe", 32'(fault_pe), 32'd0);
        check("clear_ready", 32'(bus.instr_ready), 32'd1);
        send_chain();
        wait_result("post_clear", 4, CHAIN_RES, 3);
        take_result("post_clear");

        send(pi(4'h9, 4'h4, 1'b1, 1'b1, 2'd0), 1'b1);
        wait_result("bp", 1, 4'hD, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp%0d_result", i), 32'(bus.result), 32'hD);
            check($sformatf("bp%0d_valid", i), 32'(bus.result_valid), 32'd1);
            check($sformatf("bp%0d_ready", i), 32'(bus.instr_ready), 32'd0);
        end
        take_result("bp");

        send(pi(4'h2, 4'h3, 1'b1, 1'b1, 2'd0), 1'b1);
        wait_result("pre_clr_done", 1, 4'h5, 0);
        pulse_clear();
        check("clr_done_valid", 32'(bus.result_valid), 32'd0);
        check("clr_done_ready", 32'(bus.instr_ready), 32'd1);

        send_chain();
        tick();
        reset = 1'b1;
        #1;
        check("arst_result", 32'(bus.result), 32'd0);
        check("arst_result_pe", 32'(bus.result_pe), 32'd0);
        check("arst_valid", 32'(bus.result_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(bus.instr_ready), 32'd1);
        #2;
        reset = 1'b0;
        tick();
        send(pi(4'hA, 4'h3, 1'b1, 1'b1, 2'd1), 1'b0);
        send(pi(4'h0, 4'h0, 1'b0, 1'b0, 2'd0), 1'b1);
        wait_result("after_rst", 2, 4'hE, 1);
        take_result("after_rst");

        for (int t = 0; t < 60; t++) begin
            int n;
            bit use_last;
            n        = $urandom_range(1, 4);
            use_last = (n < 4) || (($urandom % 2) != 0);
            for (int k = 0; k < n; k++) begin
                logic ia, ib;
                prog[k].a  = rnd_operand(k, ia);
                prog[k].b  = rnd_operand(k, ib);
                prog[k].ia = ia;
                prog[k].ib = ib;
                prog[k].op = 2'($urandom % 4);
            end
            run_random(n, use_last);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
